csa_accumulator: RTL

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_pkg.sv | 31 +++
 rtl/csa_compress.sv | 45 ++++
 rtl/csa_accumulator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/csa_pkg.sv
// csa_pkg -- shared definitions for the carry-save accumulator slice.
//
// Contents:
//   clog2()     : ceiling log2, usable in parameter/localparam expressions
//   out_width() : result width, operand width plus growth for every operand
//                 a single set can hold
//   state_t     : accumulator FSM state encodings
package csa_pkg;

  // Ceiling log2; clog2(1) = 0 so a degenerate one-operand set adds no bits.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = 1; v < value; v = v * 2) begin
      result++;
    end
    return result;
  endfunction

  // Enough headroom that the sum of every operand in a full set cannot wrap.
  function automatic int out_width(input int width, input int lanes, input int max_beats);
    return width + clog2(lanes * max_beats);
  endfunction

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/csa_compress.sv
// csa_compress -- combinational carry-save compressor.
//
// Reduces NUM_OPS equal-width operands to a redundant sum/carry pair using
// 3:2 full-adder layers. Each layer folds one more operand into the running
// pair, so there is never a carry-propagate chain inside this block; the
// true total is sum_row + carry_row (mod 2^WIDTH).
//
// Ports:
//   ops       : input,  NUM_OPS*WIDTH bits, operand i at [i*WIDTH +: WIDTH]
//   sum_row   : output, WIDTH bits, bitwise-sum row
//   carry_row : output, WIDTH bits, carry row (already shifted into weight)
module csa_compress
  import csa_pkg::*;
#(
  parameter int NUM_OPS = 5,
  parameter int WIDTH   = 20
) (
  input  logic [NUM_OPS*WIDTH-1:0] ops,
  output logic [WIDTH-1:0]         sum_row,
  output logic [WIDTH-1:0]         carry_row
);

  // Seed the pair with the first two operands, then apply one 3:2 layer per
  // remaining operand. The carry out of the top bit is dropped: callers size
  // WIDTH so the real total always fits.
  always_comb begin
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] majority;
    s        = ops[0 +: WIDTH];
    c        = ops[WIDTH +: WIDTH];
    addend   = '0;
    majority = '0;
    for (int i = 2; i < NUM_OPS; i++) begin
      addend   = ops[i*WIDTH +: WIDTH];
      majority = (s & c) | (s & addend) | (c & addend);
      s        = s ^ c ^ addend;
      c        = majority << 1;
    end
    sum_row   = s;
    carry_row = c;
  end

endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator -- multi-beat, multi-lane unsigned accumulator.
//
// Accepts up to MAX_BEATS beats of LANES operands each, keeps the running
// total in carry-save form (sum and carry rows) so each beat costs only a
// 3:2 tree, then resolves the pair with a single registered add before
// presenting the result. Sets never overlap: a new set starts only after the
// previous result has been consumed.
//
// Ports:
//   clk       : input,  rising-edge clock
//   rst_n     : input,  synchronous active-low reset
//   in_valid  : input,  beat present
//   in_ready  : output, accepting beats (ACCUM only)
//   in_data   : input,  LANES*WIDTH bits, lane k at [k*WIDTH +: WIDTH]
//   in_keep   : input,  LANES bits, lane k contributes only when set
//   in_last   : input,  final beat of the set
//   out_valid : output, result present (DONE only)
//   out_ready : input,  consumer takes the result
//   out_sum   : output, OUT_W bits, unsigned sum of kept operands
//   out_count : output, number of kept operands
//   out_trunc : output, set was force-closed at MAX_BEATS without in_last
module csa_accumulator
  import csa_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int LANES     = 3,
  parameter  int MAX_BEATS = 3,
  localparam int OUT_W     = out_width(WIDTH, LANES, MAX_BEATS),
  localparam int CNT_W     = clog2(LANES * MAX_BEATS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_keep,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_sum,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_trunc
);

  localparam int NUM_OPS = LANES + 2;
  localparam int BEAT_W  = clog2(MAX_BEATS + 1);
  localparam int POP_W   = clog2(LANES + 1);

  state_t                  state;
  logic [OUT_W-1:0]        acc_sum;
  logic [OUT_W-1:0]        acc_carry;
  logic [BEAT_W-1:0]       beat_count;
  logic [NUM_OPS*OUT_W-1:0] csa_ops;
  logic [OUT_W-1:0]        csa_sum;
  logic [OUT_W-1:0]        csa_carry;
  logic [POP_W-1:0]        keep_count;
  logic                    accept;
  logic                    final_beat;

  assign accept     = in_valid && in_ready;
  assign final_beat = (beat_count == BEAT_W'(MAX_BEATS - 1));

  // Build the compressor input: masked, zero-extended lanes first, then the
  // two redundant accumulator rows so the tree folds the history in too.
  always_comb begin
    csa_ops = '0;
    for (int k = 0; k < LANES; k++) begin
      if (in_keep[k]) begin
        csa_ops[k*OUT_W +: OUT_W] = OUT_W'(in_data[k*WIDTH +: WIDTH]);
      end
    end
    csa_ops[LANES*OUT_W +: OUT_W]     = acc_sum;
    csa_ops[(LANES+1)*OUT_W +: OUT_W] = acc_carry;
  end

  // Number of lanes contributing on this beat.
  always_comb begin
    keep_count = '0;
    for (int k = 0; k < LANES; k++) begin
      keep_count = keep_count + POP_W'(in_keep[k]);
    end
  end

  csa_compress #(
    .NUM_OPS (NUM_OPS),
    .WIDTH   (OUT_W)
  ) u_compress (
    .ops       (csa_ops),
    .sum_row   (csa_sum),
    .carry_row (csa_carry)
  );

  // Control FSM with registered handshakes. out_count doubles as the live
  // operand counter; it is only meaningful to the consumer while out_valid
  // is high, and nothing touches it then, so the result stays stable under
  // back-pressure. out_sum is written only in RESOLVE, so it keeps the last
  // result after consumption.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_ACCUM;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_count  <= '0;
      out_trunc  <= 1'b0;
      acc_sum    <= '0;
      acc_carry  <= '0;
      beat_count <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            acc_sum    <= csa_sum;
            acc_carry  <= csa_carry;
            out_count  <= out_count + CNT_W'(keep_count);
            beat_count <= beat_count + 1'b1;
            if (in_last || final_beat) begin
              state     <= ST_RESOLVE;
              in_ready  <= 1'b0;
              out_trunc <= !in_last;
            end
          end
        end
        ST_RESOLVE: begin
          out_sum   <= acc_sum + acc_carry;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state      <= ST_ACCUM;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            out_count  <= '0;
            out_trunc  <= 1'b0;
            acc_sum    <= '0;
            acc_carry  <= '0;
            beat_count <= '0;
          end
        end
        default: begin
          state     <= ST_ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
